semaforo_bank: RTL



---
 rtl/semaforo_bank_if.sv | 24 ++
 rtl/semaforo_bank.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/semaforo_bank_if.sv
// Lamp-driver bus: per-channel light codes and controls in, registered lamp triples and status out.
// master = sequencing controller side, slave = semaforo_bank.
interface semaforo_bank_if #(
    parameter int N_CH = 2
);
    logic [2*N_CH-1:0] light;
    logic              blink_en;
    logic              conflict_clr;
    logic [N_CH-1:0]   red;
    logic [N_CH-1:0]   yellow;
    logic [N_CH-1:0]   green;
    logic [N_CH-1:0]   busy;
    logic              conflict;

    modport master (
        output light, blink_en, conflict_clr,
        input  red, yellow, green, busy, conflict
    );

    modport slave (
        input  light, blink_en, conflict_clr,
        output red, yellow, green, busy, conflict
    );
endinterface

// File: rtl/semaforo_bank.sv
// Multi-channel traffic-light driver: per-channel lamp FSM with forced minimum yellow on green exit,
// shared blink prescaler for flashing OFF, and a sticky green-conflict interlock forcing all red.
module semaforo_bank #(
    parameter int N_CH      = 2,
    parameter int BLINK_DIV = 25000000,
    parameter int YEL_MIN   = 50000000
) (
    input  logic           clk,
    input  logic           rst_n,
    semaforo_bank_if.slave bus
);
    localparam int CW = (YEL_MIN > 1) ? $clog2(YEL_MIN) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] XYEL_LOAD  = CW'(YEL_MIN - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_RED  = 3'd0,
        S_YEL  = 3'd1,
        S_GRN  = 3'd2,
        S_OFF  = 3'd3,
        S_XYEL = 3'd4
    } state_t;

    function automatic state_t code_state(input logic [1:0] c);
        case (c)
            2'b00:   return S_RED;
            2'b01:   return S_YEL;
            2'b10:   return S_GRN;
            default: return S_OFF;
        endcase
    endfunction

    // Global blink prescaler; free-running so every channel flashes in phase.
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_ph_reg, blink_ph_next;

    always_comb begin
        blink_cnt_next = blink_cnt_reg + BW'(1);
        blink_ph_next  = blink_ph_reg;
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_ph_next  = ~blink_ph_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_ph_reg  <= 1'b1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            blink_ph_reg  <= blink_ph_next;
        end
    end

    // Interlock: two or more channels heading for green latches the conflict.
    logic [N_CH-1:0] grn_raw;
    logic            set_cond;
    logic            force_red;
    logic            conflict_reg, conflict_next;

    assign set_cond      = (grn_raw & (grn_raw - N_CH'(1))) != '0;
    assign force_red     = conflict_reg | set_cond;
    assign conflict_next = set_cond | (conflict_reg & ~bus.conflict_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign bus.conflict = conflict_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [1:0] code;
            state_t     state_reg, state_raw, state_next;
            logic [CW-1:0] cnt_reg, cnt_raw, cnt_next;
            logic       red_reg, yellow_reg, green_reg, busy_reg;
            logic       yellow_next;

            assign code = bus.light[2*gi +: 2];

            // Unforced next state; the interlock may override it below.
            always_comb begin
                state_raw = state_reg;
                cnt_raw   = cnt_reg;
                case (state_reg)
                    S_GRN: begin
                        if (code == 2'b10) begin
                            state_raw = S_GRN;
                        end else if (code == 2'b01) begin
                            state_raw = S_YEL;
                        end else begin
                            state_raw = S_XYEL;
                            cnt_raw   = XYEL_LOAD;
                        end
                    end
                    S_XYEL: begin
                        if (cnt_reg == '0) begin
                            state_raw = code_state(code);
                        end else begin
                            cnt_raw = cnt_reg - CW'(1);
                        end
                    end
                    default: state_raw = code_state(code);
                endcase
            end

            assign grn_raw[gi] = (state_raw == S_GRN);

            always_comb begin
                state_next  = force_red ? S_RED : state_raw;
                cnt_next    = force_red ? '0 : cnt_raw;
                yellow_next = (state_next == S_YEL) || (state_next == S_XYEL) ||
                              ((state_next == S_OFF) && bus.blink_en && blink_ph_next);
            end

            // Lamps are registered from the next state so they follow light with one edge of latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg  <= S_RED;
                    cnt_reg    <= '0;
                    red_reg    <= 1'b1;
                    yellow_reg <= 1'b0;
                    green_reg  <= 1'b0;
                    busy_reg   <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    red_reg    <= (state_next == S_RED);
                    yellow_reg <= yellow_next;
                    green_reg  <= (state_next == S_GRN);
                    busy_reg   <= (state_next == S_XYEL);
                end
            end

            assign bus.red[gi]    = red_reg;
            assign bus.yellow[gi] = yellow_reg;
            assign bus.green[gi]  = green_reg;
            assign bus.busy[gi]   = busy_reg;
        end
    endgenerate
endmodule
